// File: rtl/instr_fetch_ctrl.sv
// instr_fetch_ctrl: PC sequencer for a single-cycle instruction ROM with a decode handshake.
// Optional WFI halt support is enabled by defining WFI_HALT_EN.
module instr_fetch_ctrl #(
   parameter int L        = 32,
   parameter int RESET_PC = 0,
   localparam int AW      = (L > 1) ? $clog2(L) : 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   output logic [AW-1:0] rom_addr,
   output logic          rom_oe,
   input  logic [31:0]   rom_data,
   output logic [31:0]   instr,
   output logic [AW-1:0] instr_pc,
   output logic          instr_valid,
   input  logic          instr_ready,
   input  logic          redirect_valid,
   input  logic [AW-1:0] redirect_addr,
   input  logic          wake,
   output logic          halted
);

   localparam logic [AW-1:0] PC_RST = AW'(RESET_PC);
   localparam logic [AW-1:0] PC_END = AW'(L - 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      HALT
   } state_t;

   state_t        state_q;
   logic [AW-1:0] pc_q;
   logic [AW-1:0] ipc_q;
   logic [31:0]   instr_q;
   logic          valid_q;
   logic          halted_q;

   logic          fetch_en;
   logic          wfi_hit;
   logic          wake_en;
   logic [AW-1:0] pc_d;

   assign fetch_en = (state_q == RUN) & ~redirect_valid
                   & (~valid_q | instr_ready);

   // Depth need not be a power of two, so wrap explicitly.
   assign pc_d = (pc_q == PC_END) ? '0 : pc_q + 1'b1;

`ifdef WFI_HALT_EN
   localparam logic [31:0] WFI = 32'h10500073;
   assign wfi_hit = (rom_data == WFI);
   assign wake_en = wake;
`else
   logic unused_wake;
   assign unused_wake = wake;
   assign wfi_hit     = 1'b0;
   assign wake_en     = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         pc_q     <= PC_RST;
         ipc_q    <= '0;
         instr_q  <= '0;
         valid_q  <= 1'b0;
         halted_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) state_q <= RUN;
            end
            default: begin
               if (redirect_valid) begin
                  // Flush wins even over a same-cycle accept.
                  pc_q     <= redirect_addr;
                  valid_q  <= 1'b0;
                  state_q  <= RUN;
                  halted_q <= 1'b0;
               end else if (fetch_en) begin
                  instr_q <= rom_data;
                  ipc_q   <= pc_q;
                  valid_q <= 1'b1;
                  pc_q    <= pc_d;
                  if (wfi_hit) begin
                     state_q  <= HALT;
                     halted_q <= 1'b1;
                  end
               end else begin
                  if (instr_ready) valid_q <= 1'b0;
                  if (state_q == HALT && wake_en) begin
                     state_q  <= RUN;
                     halted_q <= 1'b0;
                  end
               end
            end
         endcase
      end
   end

   assign rom_addr    = pc_q;
   assign rom_oe      = fetch_en;
   assign instr       = instr_q;
   assign instr_pc    = ipc_q;
   assign instr_valid = valid_q;
   assign halted      = halted_q;

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// tb_instr_fetch_ctrl: directed and randomized checks of instr_fetch_ctrl
// against a transaction-level fetch model.
module tb_instr_fetch_ctrl;

   localparam int L  = 32;
   localparam int AW = 5;
   localparam int RESET_PC = 0;
   localparam logic [31:0] WFI = 32'h10500073;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic [AW-1:0] rom_addr;
   logic          rom_oe;
   logic [31:0]   rom_data;
   logic [31:0]   instr;
   logic [AW-1:0] instr_pc;
   logic          instr_valid;
   logic          instr_ready;
   logic          redirect_valid;
   logic [AW-1:0] redirect_addr;
   logic          wake;
   logic          halted;

   logic [31:0] rom [L];

   int checks = 0;
   int errors = 0;

   // model: mode 0 idle, 1 running, 2 halted
   int          m_mode;
   int          m_pc;
   bit          m_valid;
   logic [31:0] m_instr;
   int          m_ipc;

   instr_fetch_ctrl #(.L(L), .RESET_PC(RESET_PC)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .start          (start),
      .rom_addr       (rom_addr),
      .rom_oe         (rom_oe),
      .rom_data       (rom_data),
      .instr          (instr),
      .instr_pc       (instr_pc),
      .instr_valid    (instr_valid),
      .instr_ready    (instr_ready),
      .redirect_valid (redirect_valid),
      .redirect_addr  (redirect_addr),
      .wake           (wake),
      .halted         (halted)
   );

   always #5 clk = ~clk;

   assign rom_data = rom[rom_addr];

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h @%0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_mode  = 0;
      m_pc    = RESET_PC;
      m_valid = 1'b0;
      m_instr = '0;
      m_ipc   = 0;
   endtask

   // One clock: drive inputs after the falling edge, check, advance model.
   task automatic cyc(input bit s, input bit r, input bit rv,
                      input int ra, input bit w);
      bit fe;
      bit is_halt;
      start          = s;
      instr_ready    = r;
      redirect_valid = rv;
      redirect_addr  = AW'(ra);
      wake           = w;
      #1;
      fe = (m_mode == 1) && !rv && (!m_valid || r);
`ifdef WFI_HALT_EN
      is_halt = (m_mode == 2);
`else
      is_halt = 1'b0;
`endif
      check("rom_oe", 32'(rom_oe), 32'(fe));
      check("rom_addr", 32'(rom_addr), 32'(m_pc));
      check("valid", 32'(instr_valid), 32'(m_valid));
      check("instr", instr, m_instr);
      check("instr_pc", 32'(instr_pc), 32'(m_ipc));
      check("halted", 32'(halted), 32'(is_halt));
      if (m_mode == 0) begin
         if (s) m_mode = 1;
      end else if (rv) begin
         m_pc    = ra % L;
         m_valid = 1'b0;
         m_mode  = 1;
      end else if (fe) begin
         m_instr = rom[m_pc];
         m_ipc   = m_pc;
         m_valid = 1'b1;
         m_pc    = (m_pc + 1) % L;
`ifdef WFI_HALT_EN
         if (m_instr == WFI) m_mode = 2;
`endif
      end else begin
         if (r) m_valid = 1'b0;
`ifdef WFI_HALT_EN
         if (m_mode == 2 && w) m_mode = 1;
`endif
      end
      @(negedge clk);
   endtask

   initial begin
      for (int i = 0; i < L; i++) begin
         rom[i] = $urandom;
         if (rom[i] == WFI) rom[i] = 32'h00000013;
      end
      rom[0]  = 32'h00000093;
      rom[1]  = 32'h00700113;
      rom[4]  = 32'h003113E3;
      rom[11] = WFI;

      rst_n = 1'b0;
      start = 0; instr_ready = 0; redirect_valid = 0;
      redirect_addr = '0; wake = 0;
      model_reset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // idle, start ignored nothing else
      repeat (5) cyc(0, 1, 1, 7, 1);
      cyc(1, 0, 0, 0, 0);
      cyc(0, 1, 0, 0, 0);
      check("t1_instr", instr, 32'h00000093);
      check("t1_pc", 32'(instr_pc), 32'd0);
      cyc(0, 1, 0, 0, 0);
      check("t2_instr1", instr, 32'h00700113);
      cyc(0, 1, 0, 0, 0);
      check("t3_pc2", 32'(instr_pc), 32'd2);
      repeat (3) cyc(1, 0, 0, 0, 1);
      cyc(0, 1, 0, 0, 0);
      check("t3_pc3", 32'(instr_pc), 32'd3);
      cyc(0, 1, 1, 4, 0);
      check("t4_flush", 32'(instr_valid), 32'd0);
      cyc(0, 1, 0, 0, 0);
      check("t4_instr", instr, 32'h003113E3);
      check("t4_pc", 32'(instr_pc), 32'd4);
      repeat (7) cyc(0, 1, 0, 0, 0);
      check("t5_wfi", instr, WFI);
`ifdef WFI_HALT_EN
      repeat (10) cyc(0, 1, 0, 0, 0);
      check("t5_halt", 32'(halted), 32'd1);
      cyc(0, 1, 0, 0, 1);
      cyc(0, 1, 0, 0, 0);
      check("t5_resume", 32'(instr_pc), 32'd12);
`endif
      cyc(0, 1, 1, 31, 0);
      cyc(0, 1, 0, 0, 0);
      check("t5_pc31", 32'(instr_pc), 32'd31);
      cyc(0, 1, 0, 0, 0);
      check("t5_wrap", 32'(instr_pc), 32'd0);

      // async reset while decode stalls
      cyc(0, 0, 0, 0, 0);
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      check("t6_valid", 32'(instr_valid), 32'd0);
      check("t6_pc", 32'(rom_addr), 32'(RESET_PC));
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) cyc(0, 1, 0, 0, 0);

      // randomized traffic with occasional resets
      for (int n = 0; n < 3000; n++) begin
         if (n % 500 == 499) begin
            #2 rst_n = 1'b0;
            model_reset();
            @(negedge clk);
            rst_n = 1'b1;
         end
         cyc(($urandom_range(0, 9) == 0),
             ($urandom_range(0, 9) < 7),
             ($urandom_range(0, 9) == 0),
             int'($urandom_range(0, L - 1)),
             ($urandom_range(0, 7) == 0));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
